// File: rtl/btn_debounce_multi_if.sv
// Signal bundle between the raw button pins and the debouncer.
// Slave is the debouncer; master is whoever drives the pins and consumes the events.
interface btn_debounce_multi_if #(
  parameter int N = 4
);
  logic [N-1:0] btn;
  logic         rtg_btn;
  logic [N-1:0] btn_output_state;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic [N-1:0] repeat_pulse;
  logic         any_pressed;

  modport master (
    output btn,
    output rtg_btn,
    input  btn_output_state,
    input  press,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse,
    input  any_pressed
  );

  modport slave (
    input  btn,
    input  rtg_btn,
    output btn_output_state,
    output press,
    output release_pulse,
    output long_press,
    output repeat_pulse,
    output any_pressed
  );
endinterface

// File: rtl/btn_debounce_multi.sv
// N-channel button debouncer: 2-FF synchroniser, strobe-sampled stability filter,
// and per-channel press/release/long-press/auto-repeat event pulses.
module btn_debounce_multi #(
  parameter int N              = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_SAMPLES   = 16,
  parameter int REPEAT_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_debounce_multi_if.slave  bus
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam int HW = $clog2(LONG_SAMPLES + REPEAT_SAMPLES + 1);

  localparam logic [CW-1:0] CNT_LAST     = CW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LONG_M1 = HW'(LONG_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LONG    = HW'(LONG_SAMPLES);
  localparam logic [HW-1:0] HOLD_WRAP_M1 = HW'(LONG_SAMPLES + REPEAT_SAMPLES - 1);

  logic [N-1:0]  sync_q1;
  logic [N-1:0]  btn_sync;
  logic [N-1:0]  state_q;
  logic [N-1:0]  state_d;
  logic [CW-1:0] cnt_q  [N];
  logic [CW-1:0] cnt_d  [N];
  logic [HW-1:0] hold_q [N];
  logic [HW-1:0] hold_d [N];
  logic [N-1:0]  press_d;
  logic [N-1:0]  release_d;
  logic [N-1:0]  long_d;
  logic [N-1:0]  repeat_d;
  logic [N-1:0]  press_q;
  logic [N-1:0]  release_q;
  logic [N-1:0]  long_q;
  logic [N-1:0]  repeat_q;
  logic          any_q;

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      hold_d[i] = hold_q[i];
      if (bus.rtg_btn) begin
        // Any matching sample throws away the whole mismatch run.
        if (btn_sync[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]     = '0;
          state_d[i]   = ~state_q[i];
          press_d[i]   = ~state_q[i];
          release_d[i] = state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end

        // Released (or release tick) and the press tick itself both restart the hold timer.
        if (!state_d[i] || press_d[i]) begin
          hold_d[i] = '0;
        end else if (hold_q[i] == HOLD_LONG_M1) begin
          long_d[i] = 1'b1;
          hold_d[i] = hold_q[i] + 1'b1;
        end else if (REPEAT_SAMPLES > 0) begin
          if (hold_q[i] == HOLD_WRAP_M1) begin
            repeat_d[i] = 1'b1;
            hold_d[i]   = HOLD_LONG;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end else if (hold_q[i] != HOLD_LONG) begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= '0;
      btn_sync  <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync_q1   <= bus.btn;
      btn_sync  <= sync_q1;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      any_q     <= |state_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.btn_output_state = state_q;
  assign bus.press            = press_q;
  assign bus.release_pulse    = release_q;
  assign bus.long_press       = long_q;
  assign bus.repeat_pulse     = repeat_q;
  assign bus.any_pressed      = any_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: per-cycle vector table with the strobe held
// high, then 1-in-8 strobe sequences for bounce, long/repeat, simultaneous and reset.
module tb_btn_debounce_multi;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_debounce_multi_if #(.N(N)) bus0 ();
  btn_debounce_multi_if #(.N(N)) bus1 ();
  assign bus1.btn     = bus0.btn;
  assign bus1.rtg_btn = bus0.rtg_btn;

  btn_debounce_multi #(
    .N(N), .STABLE_SAMPLES(4), .LONG_SAMPLES(16), .REPEAT_SAMPLES(4)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  btn_debounce_multi #(
    .N(N), .STABLE_SAMPLES(4), .LONG_SAMPLES(16), .REPEAT_SAMPLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       rtg;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;
  int smp;
  int press_n [N];
  int press_at[N];
  int rel_n   [N];
  int rel_at  [N];
  int long_n  [N];
  int long_at [N];
  int rep_n   [N];
  int long_n1 [N];
  int long_at1[N];
  int rep_n1;
  int rep1_at[$];
  int press_cycles;
  bit simul_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic [3:0] b, input logic g,
                         input logic [3:0] s, input logic [3:0] p,
                         input logic [3:0] l, input logic a);
    vec_t v;
    v.rst = r; v.btn = b; v.rtg = g; v.st = s; v.pr = p; v.rl = l; v.any = a;
    vecs.push_back(v);
  endtask

  task automatic clear_records();
    for (int i = 0; i < N; i++) begin
      press_n[i] = 0; press_at[i] = -1; rel_n[i] = 0; rel_at[i] = -1;
      long_n[i] = 0; long_at[i] = -1; rep_n[i] = 0; long_n1[i] = 0; long_at1[i] = -1;
    end
    rep_n1 = 0;
    rep1_at.delete();
    press_cycles = 0;
    simul_seen = 1'b0;
  endtask

  task automatic cyc(input logic g);
    bus0.rtg_btn = g;
    @(posedge clk);
    #1;
    if (g) smp++;
    for (int i = 0; i < N; i++) begin
      if (bus0.press[i])         begin press_n[i]++; press_at[i] = smp; end
      if (bus0.release_pulse[i]) begin rel_n[i]++;   rel_at[i]   = smp; end
      if (bus0.long_press[i])    begin long_n[i]++;  long_at[i]  = smp; end
      if (bus0.repeat_pulse[i]) begin
        rep_n[i]++;
        if (i == 1) rep1_at.push_back(smp);
      end
      if (bus1.long_press[i])    begin long_n1[i]++; long_at1[i] = smp; end
      if (bus1.repeat_pulse[i])  rep_n1++;
    end
    if (bus0.press != '0) press_cycles++;
    if (bus0.press == 4'hF && bus0.any_pressed) simul_seen = 1'b1;
    bus0.rtg_btn = 1'b0;
  endtask

  task automatic samples(input int n);
    repeat (n) begin
      repeat (7) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.btn = '0;
    bus0.rtg_btn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp = 0;
    clear_records();
  endtask

  int s0;
  int r0;
  int ra;

  initial begin
    rst = 1'b1;
    bus0.btn = '0;
    bus0.rtg_btn = 1'b0;
    smp = 0;
    clear_records();

    // Strobe stuck high: filter samples every clock, sync delay is 2 clocks.
    add_vec(1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0);
    add_vec(1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 0);
    for (int k = 2; k <= 6; k++) add_vec(0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 0);
    add_vec(0, 4'h1, 1, 4'h1, 4'h1, 4'h0, 1);
    add_vec(0, 4'h1, 1, 4'h1, 4'h0, 4'h0, 1);
    for (int k = 9; k <= 13; k++) add_vec(0, 4'h0, 1, 4'h1, 4'h0, 4'h0, 1);
    add_vec(0, 4'h0, 1, 4'h0, 4'h0, 4'h1, 0);
    for (int k = 15; k <= 17; k++) add_vec(0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 0);
    for (int k = 18; k <= 21; k++) add_vec(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    for (int k = 22; k <= 27; k++) add_vec(0, 4'h2, 0, 4'h0, 4'h0, 4'h0, 0);
    for (int k = 28; k <= 30; k++) add_vec(0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0);
    add_vec(0, 4'h2, 1, 4'h2, 4'h2, 4'h0, 1);
    add_vec(0, 4'h2, 1, 4'h2, 4'h0, 4'h0, 1);

    foreach (vecs[k]) begin
      rst = vecs[k].rst;
      bus0.btn = vecs[k].btn;
      bus0.rtg_btn = vecs[k].rtg;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_state", k), bus0.btn_output_state, vecs[k].st);
      chk($sformatf("vec%0d_press", k), bus0.press, vecs[k].pr);
      chk($sformatf("vec%0d_release", k), bus0.release_pulse, vecs[k].rl);
      chk($sformatf("vec%0d_any", k), bus0.any_pressed, vecs[k].any);
      chk($sformatf("vec%0d_state_norep", k), bus1.btn_output_state, vecs[k].st);
    end

    // Bounce: 3-sample runs never flip state; final edge needs 4 samples.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      bus0.btn[0] = ~bus0.btn[0];
      samples(3);
    end
    chk("bounce_no_press", press_n[0], 0);
    chk("bounce_state_idle", bus0.btn_output_state, 4'h0);
    s0 = smp;
    bus0.btn[0] = 1'b1;
    samples(6);
    chk("bounce_press_count", press_n[0], 1);
    chk("bounce_press_sample", press_at[0], s0 + 4);
    chk("bounce_state_final", bus0.btn_output_state, 4'b0001);

    // Long press and auto-repeat on channel 1; dut1 has repeat disabled.
    do_reset();
    s0 = smp;
    bus0.btn = 4'b0010;
    samples(4);
    chk("long_press_sample", press_at[1], s0 + 4);
    samples(40);
    chk("long_count", long_n[1], 1);
    chk("long_sample", long_at[1], s0 + 4 + 16);
    chk("repeat_count", rep_n[1], 6);
    ra = (rep1_at.size() > 0) ? rep1_at[0] : -1;
    chk("repeat_first", ra, s0 + 4 + 20);
    ra = (rep1_at.size() > 1) ? rep1_at[1] : -1;
    chk("repeat_second", ra, s0 + 4 + 24);
    ra = (rep1_at.size() > 2) ? rep1_at[2] : -1;
    chk("repeat_third", ra, s0 + 4 + 28);
    chk("norep_long_count", long_n1[1], 1);
    chk("norep_long_sample", long_at1[1], s0 + 4 + 16);
    chk("norep_repeat_count", rep_n1, 0);
    r0 = smp;
    bus0.btn = 4'b0000;
    samples(20);
    chk("release_count", rel_n[1], 1);
    chk("release_sample", rel_at[1], r0 + 4);
    chk("repeat_after_release", rep_n[1], 6);
    chk("long_after_release", long_n[1], 1);
    chk("release_state", bus0.btn_output_state, 4'h0);
    chk("release_any", bus0.any_pressed, 1'b0);

    // All four channels in the same clock.
    do_reset();
    bus0.btn = 4'hF;
    samples(5);
    chk("simul_press_and_any", simul_seen, 1'b1);
    chk("simul_press_cycles", press_cycles, 1);
    chk("simul_state", bus0.btn_output_state, 4'hF);
    chk("simul_any", bus0.any_pressed, 1'b1);

    // Reset mid-count: channel 0 already pressed, channel 2 three samples in.
    do_reset();
    bus0.btn = 4'b0001;
    samples(5);
    chk("rstmid_pre_state", bus0.btn_output_state, 4'b0001);
    bus0.btn = 4'b0101;
    samples(3);
    chk("rstmid_partial_state", bus0.btn_output_state, 4'b0001);
    rst = 1'b1;
    bus0.rtg_btn = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.rtg_btn = 1'b0;
    chk("rstmid_state", bus0.btn_output_state, 4'h0);
    chk("rstmid_any", bus0.any_pressed, 1'b0);
    chk("rstmid_press", bus0.press, 4'h0);
    r0 = smp;
    press_n[2] = 0;
    samples(6);
    chk("rstmid_press2_count", press_n[2], 1);
    chk("rstmid_press2_sample", press_at[2], r0 + 4);
    chk("rstmid_press0_sample", press_at[0], r0 + 4);
    chk("rstmid_final_state", bus0.btn_output_state, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel button debouncer, successor to the single-channel `btn_debounce`. It synchronises N raw button inputs and filters them against a shared sample strobe `rtg_btn`. For each channel it produces a debounced level, one-clock press/release pulses, a long-press pulse and an optional auto-repeat pulse. It sits between the board button pins and the user-interface control logic.

## Interface
- `N`, 4, number of independent button channels (1..32).
- `STABLE_SAMPLES`, 4, consecutive strobe samples of the opposite level needed to flip a debounced state (>=1).
- `LONG_SAMPLES`, 16, strobe samples held after the press before `long_press` fires (>=1).
- `REPEAT_SAMPLES`, 4, strobe samples between successive `repeat` pulses after a long press; 0 disables repeat.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn`  in  N  raw asynchronous button levels, 1 = pressed.
- `rtg_btn`  in  1  sample strobe, synchronous to `clk`; any high cycle is one sample.
- `btn_output_state`  out  N  debounced level per channel.
- `press`  out  N  one-clock pulse on a debounced 0->1 transition.
- `release`  out  N  one-clock pulse on a debounced 1->0 transition.
- `long_press`  out  N  one-clock pulse when a press has been held `LONG_SAMPLES` samples.
- `repeat`  out  N  one-clock pulse every `REPEAT_SAMPLES` samples after `long_press`.
- `any_pressed`  out  1  OR-reduction of `btn_output_state`.

## Operation
- Synchroniser: 2-FF chain per channel; `btn_sync` is `btn` delayed 2 clocks. Only `btn_sync` feeds the filter.
- Stability counter `cnt[i]` is `$clog2(STABLE_SAMPLES+1)` bits. It is evaluated only in cycles with `rtg_btn`=1:
  - If `btn_sync[i]` == state: `cnt` <= 0.
  - Otherwise, if `cnt+1` == `STABLE_SAMPLES`: the state toggles, `cnt` <= 0, and `press` or `release` asserts.
  - Otherwise `cnt` <= `cnt+1`.
- A mismatch run broken by a single matching sample restarts from 0. There is no partial credit.
- Hold counter `hold[i]` is `$clog2(LONG_SAMPLES+REPEAT_SAMPLES+1)` bits:
  - Cleared on a press tick and whenever the state is 0.
  - On each later tick with state=1, `hold` <= `hold+1`.
  - When `hold+1` == `LONG_SAMPLES`, `long_press` asserts.
  - With `REPEAT_SAMPLES`>0: when `hold+1` == `LONG_SAMPLES+REPEAT_SAMPLES`, `repeat` asserts and `hold` <= `LONG_SAMPLES`. This gives a periodic repeat.
  - With `REPEAT_SAMPLES`=0: `hold` saturates at `LONG_SAMPLES` and `repeat` stays 0.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- The release tick clears `hold` and suppresses any `long_press` or `repeat` on that tick.

## Timing
- Reset values: all outputs 0, `btn_sync` 0, `cnt` 0, `hold` 0. `rst` overrides `rtg_btn`.
- Reset mid-count discards partial counts. After `rst` falls, a button held at 1 needs the full 2 clocks plus `STABLE_SAMPLES` samples to register.
- All outputs are registered. State, `press`, `release`, `long_press` and `repeat` update on the clock edge ending the strobe cycle that triggered them.
- `press` is high in exactly the first cycle where `btn_output_state[i]`=1. `release` behaves the same for the first 0 cycle.
- Every pulse lasts exactly one clock, even if `rtg_btn` is held high continuously.
- With `rtg_btn` stuck at 1, the filter samples every clock. Minimum latency from a `btn` edge to a state change is then 2+`STABLE_SAMPLES` clocks.
- With `rtg_btn`=0, no state, counter or pulse changes occur; only the synchroniser runs.
- Bounce shorter than `STABLE_SAMPLES` consecutive samples never changes state.

## Test plan
All scenarios use N=4, STABLE_SAMPLES=4, LONG_SAMPLES=16, REPEAT_SAMPLES=4, and `rtg_btn` pulsed 1 clock every 8 clocks.
- Bounce: toggle `btn[0]` every 3 samples for 8 toggles, then hold at 1. Expect no `press` during bounce. Exactly one `press[0]` on the 4th sample after the final edge has reached `btn_sync`. `btn_output_state`=4'b0001.
- Long/repeat: hold `btn[1]` for 30 samples after press. Expect `long_press[1]` 16 samples after `press`, then `repeat[1]` at +20, +24, +28. On release, after 4 samples: `release[1]`, and no pulses after that.
- Simultaneous: assert `btn[3:0]`=4'hF in one clock. Expect `press`=4'hF in one cycle and `any_pressed`=1 in the same cycle.
- Reset mid-operation: assert `rst` for 1 clock after 3 matching samples of `btn[2]`=1. Expect all outputs 0. `press[2]` only 4 samples after the reset cycle plus 2 sync clocks.
- Strobe stuck high: set `rtg_btn`=1 continuously and a `btn[0]` 0->1 step. Expect `btn_output_state[0]`=1 exactly 6 clocks later, with a `press` exactly one clock wide.
- Repeat disabled: build with REPEAT_SAMPLES=0 and hold 40 samples. Expect one `long_press`, `repeat` always 0, and `hold` saturated at 16.
